// File: rtl/lsu_mem_port_if.sv
// Bus bundle for the load/store unit: CPU-side request/response and
// memory-side request/data. The slave view belongs to lsu_mem_port and the
// master view to whatever drives the CPU and memory sides.
interface lsu_mem_port_if #(
   parameter int ADDR_W = 32
) ();
   logic              req_valid;
   logic              req_we;
   logic [2:0]        req_func3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              stall;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              mem_req;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_func3, req_addr, req_wdata,
      input  mem_ready, mem_rdata,
      output stall, rsp_valid, rsp_rdata, rsp_err,
      output mem_req, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_func3, req_addr, req_wdata,
      output mem_ready, mem_rdata,
      input  stall, rsp_valid, rsp_rdata, rsp_err,
      input  mem_req, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between the single-cycle datapath and a variable-latency
// data memory. Checks the access, issues one memory request, stalls the
// core until the memory answers and returns extended load data.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for req_valid; decode and check the request
// S_WAIT | mem_req held high with stable addr/be/wdata until mem_ready
// S_DONE | one-cycle rsp_valid (rsp_err from the check); back to idle
module lsu_mem_port #(
   parameter int ADDR_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   lsu_mem_port_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [2:0]        func3_q;
   logic [1:0]        lane_q;
   logic              we_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   logic [1:0]        lane;
   logic              illegal;
   logic              misaligned;
   logic              req_bad;
   logic [3:0]        be_calc;
   logic [31:0]       wdata_calc;
   logic [31:0]       rd_shift;
   logic [31:0]       load_ext;

   // Request decode: legality, alignment, byte enables and lane-shifted data.
   always_comb begin
      lane       = bus.req_addr[1:0];
      illegal    = 1'b0;
      misaligned = 1'b0;
      be_calc    = 4'b0000;
      if (bus.req_we) begin
         illegal = (bus.req_func3 > 3'd2);
      end else begin
         illegal = (bus.req_func3 == 3'd3) || (bus.req_func3 == 3'd6) ||
                   (bus.req_func3 == 3'd7);
      end
      case (bus.req_func3[1:0])
         2'd1:    misaligned = lane[0];
         2'd2:    misaligned = (lane != 2'd0);
         default: misaligned = 1'b0;
      endcase
      if (bus.req_we) begin
         case (bus.req_func3[1:0])
            2'd0:    be_calc = 4'b0001 << lane;
            2'd1:    be_calc = 4'b0011 << lane;
            default: be_calc = 4'b1111;
         endcase
      end
      req_bad    = illegal || misaligned;
      wdata_calc = bus.req_wdata << {lane, 3'b000};
   end

   // Load extraction from the captured lane of the returned word.
   always_comb begin
      rd_shift = bus.mem_rdata >> {lane_q, 3'b000};
      case (func3_q)
         3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_ext = {24'h0, rd_shift[7:0]};
         3'b101:  load_ext = {16'h0, rd_shift[15:0]};
         default: load_ext = rd_shift;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req_valid) state_d = req_bad ? S_DONE : S_WAIT;
         S_WAIT:  if (bus.mem_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture in idle and load-data capture on memory completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         func3_q <= 3'b000;
         lane_q  <= 2'b00;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else if (state_q == S_IDLE && bus.req_valid) begin
         if (req_bad) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
         end else begin
            err_q   <= 1'b0;
            addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            func3_q <= bus.req_func3;
            lane_q  <= lane;
            we_q    <= bus.req_we;
         end
      end else if (state_q == S_WAIT && bus.mem_ready && !we_q) begin
         rdata_q <= load_ext;
      end
   end

   // Outputs decoded from state and captured registers.
   always_comb begin
      bus.mem_req   = (state_q == S_WAIT);
      bus.mem_be    = be_q;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      bus.rsp_valid = (state_q == S_DONE);
      bus.rsp_err   = (state_q == S_DONE) && err_q;
      bus.rsp_rdata = rdata_q;
      bus.stall     = bus.req_valid && (state_q != S_DONE);
   end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port. Each access is described by its request
// and the memory's wait count; a timeline model derives per-cycle outputs
// and a negedge compare process checks the DUT against it.
module tb_lsu_mem_port;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   lsu_mem_port_if #(.ADDR_W(32)) bus ();

   lsu_mem_port #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // expected per-cycle outputs
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_mem_req, exp_rsp_valid, exp_rsp_err, exp_bus_chk;
   logic [3:0]  exp_be;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;

   int          last_rsp_cyc = -1;
   int          first_req_cyc = -1;
   logic [31:0] last_rdata = 32'h0;
   logic        prev_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Compare process.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'h0, bus.stall}, {31'h0, exp_stall});
         chk("mem_req", {31'h0, bus.mem_req}, {31'h0, exp_mem_req});
         chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, exp_rsp_valid});
         chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, exp_rsp_err});
         chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
         if (exp_bus_chk) begin
            chk("mem_be", {28'h0, bus.mem_be}, {28'h0, exp_be});
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_wdata", bus.mem_wdata, exp_wdata);
         end
      end
      if (bus.rsp_valid === 1'b1) begin
         last_rsp_cyc = cyc;
         last_rdata   = bus.rsp_rdata;
      end
      if (bus.mem_req === 1'b1 && !prev_req) first_req_cyc = cyc;
      prev_req = (bus.mem_req === 1'b1);
   end

   // Model of the access rules.
   function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int bytes;
      logic legal;
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      bytes = 1 << f3[1:0];
      return !legal || ((a % bytes) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
      int n;
      if (!we) return 4'b0000;
      n = 1 << f3[1:0];
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (a % 4));
      case (f3)
         3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
         3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
         3'd4: v = v & 32'hFF;
         3'd5: v = v & 32'hFFFF;
         default: ;
      endcase
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_exp();
      exp_stall     = 1'b0;
      exp_mem_req   = 1'b0;
      exp_rsp_valid = 1'b0;
      exp_rsp_err   = 1'b0;
      exp_bus_chk   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.req_valid = 1'b0;
         bus.mem_ready = i[0];
         bus.mem_rdata = 32'hA5A5_5A5A;
         idle_exp();
         step();
      end
   endtask

   task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int waits, input logic [31:0] rd);
      logic e;
      int   rc, rdy;
      e   = m_err(we, f3, a);
      rdy = waits + 1;
      rc  = e ? 1 : waits + 2;
      for (int c = 0; c <= rc; c++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = we;
         bus.req_func3 = f3;
         bus.req_addr  = a;
         bus.req_wdata = wd;
         bus.mem_ready = e ? 1'b1 : (c == rdy);
         bus.mem_rdata = (c == rdy) ? rd : 32'h0BAD_0BAD;
         exp_stall     = (c < rc);
         exp_mem_req   = !e && c >= 1 && c <= rdy;
         exp_bus_chk   = exp_mem_req;
         exp_be        = m_be(we, f3, a);
         exp_addr      = a & ~32'h3;
         exp_wdata     = wd << (8 * (a % 4));
         exp_rsp_valid = (c == rc);
         exp_rsp_err   = (c == rc) && e;
         if (c == rc) begin
            if (e)       exp_rdata = 32'h0;
            else if (!we) exp_rdata = m_load(f3, a, rd);
         end
         step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1);
   end

   initial begin
      int r1;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_func3 = 3'd0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      idle_exp();
      exp_bus_chk = 1'b1;
      exp_be = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
      step();
      chk_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      idle(2);

      run(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
      chk("lw_lit", last_rdata, 32'hDEADBEEF);
      run(1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80FFFFFF);
      chk("lb_lit", last_rdata, 32'hFFFFFF80);
      run(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80FFFFFF);
      chk("lbu_lit", last_rdata, 32'h00000080);
      run(1'b0, 3'd5, 32'h102, 32'h0, 2, 32'hBEEF0000);
      chk("lhu_lit", last_rdata, 32'h0000BEEF);
      run(1'b0, 3'd1, 32'h102, 32'h0, 0, 32'hBEEF0000);
      chk("lh_lit", last_rdata, 32'hFFFFBEEF);
      run(1'b1, 3'd1, 32'h206, 32'h1234, 4, 32'h0);
      chk("sh_rsp_cyc", last_rsp_cyc - first_req_cyc, 32'd5);
      chk("sh_keep_rdata", last_rdata, 32'hFFFFBEEF);
      run(1'b1, 3'd0, 32'h201, 32'hAB, 2, 32'h0);
      idle(3);
      run(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
      chk("lw_mis_lit", last_rdata, 32'h0);
      run(1'b1, 3'd1, 32'h003, 32'h55, 0, 32'h0);
      run(1'b0, 3'd3, 32'h000, 32'h0, 0, 32'h0);
      run(1'b1, 3'd4, 32'h000, 32'h0, 0, 32'h0);
      run(1'b0, 3'd2, 32'h010, 32'h0, 1, 32'h12345678);
      chk("lw2_lit", last_rdata, 32'h12345678);

      // reset in the middle of a waiting load
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_func3 = 3'd2;
      bus.req_addr = 32'h40; bus.mem_ready = 1'b0;
      idle_exp(); exp_stall = 1'b1;
      step();
      exp_mem_req = 1'b1; exp_bus_chk = 1'b1;
      exp_be = 4'h0; exp_addr = 32'h40; exp_wdata = 32'h0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req_valid = 1'b0;
      idle_exp();
      exp_bus_chk = 1'b1;
      exp_be = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = 32'hCAFEF00D;
         step();
      end
      chk("rst_rdata_lit", bus.rsp_rdata, 32'h0);
      idle(1);

      // back-to-back stores with zero-wait memory
      run(1'b1, 3'd2, 32'h0, 32'h11111111, 0, 32'h0);
      r1 = last_rsp_cyc;
      run(1'b1, 3'd2, 32'h4, 32'h22222222, 0, 32'h0);
      chk("b2b_gap", first_req_cyc - r1, 32'd2);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the single-cycle datapath and a data memory with variable latency. It issues the memory access for the current LOAD or STORE instruction, stalls the PC and register file until the memory answers, and delivers sign- or zero-extended load data for writeback. It generates byte enables internally from func3 and the address, and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both CPU and memory sides.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  current instruction is LOAD or STORE; held high until stall drops.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I load/store func3.
- req_addr  in  ADDR_W  effective byte address (rs1 + imm).
- req_wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and register writes.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load result.
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal func3.
- mem_req  out  1  memory request, held until accepted.
- mem_be  out  4  byte write enables; 0000 for loads.
- mem_addr  out  ADDR_W  word-aligned address (low two bits 0).
- mem_wdata  out  32  lane-shifted store data.
- mem_ready  in  1  memory accepts/completes in a cycle where mem_req=1.
- mem_rdata  in  32  read word, valid with mem_ready.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With req_valid=1, check the request.
  - Illegal func3: loads 011/110/111, stores anything but 000/001/010.
  - Misaligned: half accesses with addr[0]=1; word accesses with addr[1:0]≠0.
  - On an error, go to DONE with error flag set and no memory access.
  - Otherwise register addr, be, wdata, func3 and lane, then go to WAIT.
- WAIT:
  - mem_req=1; mem_addr, mem_be and mem_wdata stay stable.
  - On mem_ready=1, capture the extended load data (loads only) and go to DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, with rsp_err equal to the error flag; then go to IDLE.
  - req_valid is ignored in DONE because it still belongs to the finished instruction.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 << addr[1:0].
  - sw: 1111.
- mem_wdata = req_wdata << (8*addr[1:0]).
- Load extract: byte/half taken from lane addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- rsp_rdata:
  - Updated only on a successful load.
  - Forced to 0 on an error.
  - Unchanged after a store.
- stall = req_valid & (state ≠ DONE), combinational.

## Timing
- Reset values: state IDLE, mem_req 0, mem_be 0000, mem_addr 0, mem_wdata 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
- Latency for a normal access:
  - Request seen in IDLE at cycle 0; mem_req high from cycle 1.
  - If mem_ready arrives at cycle k ≥ 1, rsp_valid is at cycle k+1 and stall drops at cycle k+1.
  - Zero-wait memory gives 3 cycles per access.
- Latency for an error: rsp_valid at cycle 1 and mem_req never asserted.
- mem_ready while mem_req=0 is ignored.
- Back-to-back requests: a new req_valid is accepted in the IDLE cycle after DONE.
- Reset mid-access (in WAIT or DONE):
  - Next cycle goes to IDLE with all outputs at reset values.
  - The in-flight memory transaction is abandoned and any later mem_ready is ignored.
- rsp_valid and rsp_err never assert outside DONE.

## Test plan
- lw at 0x100, mem_ready on the first mem_req cycle, mem_rdata=0xDEADBEEF -> mem_be=0000, mem_addr=0x100, rsp_rdata=0xDEADBEEF, rsp_valid at cycle 2, stall high for cycles 0–1.
- lb at 0x103 with mem_rdata=0x80FFFFFF -> rsp_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080; lhu at 0x102 with rdata=0xBEEF0000 -> 0x0000BEEF.
- sh at 0x206 with wdata=0x1234 and 4 wait cycles -> mem_be=1100, mem_addr=0x204, mem_wdata=0x12340000 stable across waits, rsp_valid at cycle 6, rsp_rdata unchanged.
- lw at 0x101, then sh at 0x3, then func3=011 load -> each gives rsp_err=1 with rsp_valid at cycle 1, mem_req never high, rsp_rdata=0.
- rst asserted in WAIT, then mem_ready pulses after reset -> IDLE, mem_req=0, no rsp_valid, all outputs at reset values.
- Two back-to-back sw at 0x0 and 0x4 with zero-wait memory -> second mem_req starts 2 cycles after the first rsp_valid, each with mem_be=1111.
